// File: rtl/spi_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_cfg_sequencer
// Description : System-clock-domain sequencer behind the SPI peripheral.
//               Oversamples SCK/CS, captures each 16-bit frame mid-frame,
//               executes it as a config-register command (shadow writes,
//               commit, pipelined reads) and applies committed shadows to
//               the active set on the next PWM period boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cfg_sequencer #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 3,
  parameter int NUM_CFG = 6,
  parameter int SETTLE  = 2
) (
  input  logic                      clk,
  input  logic                      rst_internal,
  input  logic                      sck,
  input  logic                      cs,
  input  logic [15:0]               copi_word,
  input  logic [DATA_W-1:0]         status_in,
  input  logic                      pwm_sync,
  output logic [15:0]               data_send,
  output logic [NUM_CFG*DATA_W-1:0] cfg_out,
  output logic                      cfg_update,
  output logic                      commit_pending,
  output logic                      frame_err
);

  // Frame layout: W flag on top, address below it, payload in the low bits.
  localparam int                c_W_BIT       = 15;
  localparam int                c_ADDR_MSB    = 14;
  localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(7);
  localparam logic [4:0]        c_FRAME_BITS  = 5'd16;
  localparam int                c_SETTLE_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE  = c_SETTLE_W'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECV     = 3'd1,
    S_HOLD     = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_END = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_sck_meta;
  logic                    r_sck_sync;
  logic                    r_sck_prev;
  logic                    r_cs_meta;
  logic                    r_cs_sync;

  logic [4:0]              r_edge_cnt;
  logic [c_SETTLE_W-1:0]   r_settle;
  logic [15:0]             r_cmd;
  logic [15:0]             r_rd_buf;
  logic [15:0]             r_data_send;
  logic                    r_commit_pending;
  logic                    r_frame_err;
  logic                    r_cfg_update;
  logic [DATA_W-1:0]       r_shadow [NUM_CFG];
  logic [DATA_W-1:0]       r_active [NUM_CFG];

  logic                    w_sck_rise;
  logic                    w_cs_low;
  logic                    w_cnt_clr;
  logic                    w_settle_clr;
  logic                    w_capture;
  logic                    w_exec;
  logic                    w_abort;
  logic                    w_reply_load;
  logic                    w_apply;
  logic                    w_cmd_wr;
  logic [ADDR_W-1:0]       w_cmd_addr;
  logic [DATA_W-1:0]       w_cmd_data;
  logic                    w_exec_wr;
  logic                    w_exec_rd;
  logic                    w_commit_wr;
  logic [DATA_W-1:0]       w_rd_value;

  assign w_sck_rise   = r_sck_sync & ~r_sck_prev;
  assign w_cs_low     = ~r_cs_sync;

  assign w_cmd_wr     = r_cmd[c_W_BIT];
  assign w_cmd_addr   = r_cmd[c_ADDR_MSB -: ADDR_W];
  assign w_cmd_data   = r_cmd[DATA_W-1:0];
  assign w_exec_wr    = w_exec & w_cmd_wr;
  assign w_exec_rd    = w_exec & ~w_cmd_wr;
  assign w_commit_wr  = w_exec_wr & (w_cmd_addr == c_ADDR_CTRL) & w_cmd_data[0];
  assign w_apply      = pwm_sync & r_commit_pending;

  // Two-flop synchronizers for the raw SPI pins; CS idles high, so it resets high.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_cs_meta  <= 1'b1;
      r_cs_sync  <= 1'b1;
    end else begin
      r_sck_meta <= sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_cs_meta  <= cs;
      r_cs_sync  <= r_cs_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: next state plus one-cycle strobes for the datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_clr    = 1'b0;
    w_settle_clr = 1'b0;
    w_capture    = 1'b0;
    w_exec       = 1'b0;
    w_abort      = 1'b0;
    w_reply_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_low) begin
          w_state_nxt = S_RECV;
          w_cnt_clr   = 1'b1;
        end
      end
      S_RECV: begin
        // A full count wins over CS rising in the same cycle.
        if (r_edge_cnt == c_FRAME_BITS) begin
          w_state_nxt  = S_HOLD;
          w_settle_clr = 1'b1;
        end else if (!w_cs_low) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        // The peripheral word needs SETTLE cycles after the last bit, and
        // must be taken before CS rises because the peripheral clears it.
        if (r_settle == c_SETTLE) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (!w_cs_low) begin
          w_reply_load = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // SCK rise counter; saturates at 16 so stray edges cannot wrap it.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_edge_cnt <= 5'd0;
    end else if (w_cnt_clr) begin
      r_edge_cnt <= 5'd0;
    end else if ((r_state == S_RECV) && w_sck_rise && (r_edge_cnt != c_FRAME_BITS)) begin
      r_edge_cnt <= r_edge_cnt + 5'd1;
    end
  end

  // Settle delay counter used while holding for the peripheral word.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_settle <= '0;
    end else if (w_settle_clr) begin
      r_settle <= '0;
    end else if ((r_state == S_HOLD) && (r_settle != c_SETTLE)) begin
      r_settle <= r_settle + c_SETTLE_W'(1);
    end
  end

  // Command capture from the peripheral receive word.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_cmd <= 16'h0000;
    end else if (w_capture) begin
      r_cmd <= copi_word;
    end
  end

  // Read-data selection for the command being executed.
  always_comb begin
    w_rd_value = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (w_cmd_addr == ADDR_W'(k)) begin
        w_rd_value = r_active[k];
      end
    end
    if (w_cmd_addr == c_ADDR_STATUS) begin
      w_rd_value = status_in;
    end
    if (w_cmd_addr == c_ADDR_CTRL) begin
      w_rd_value = {{(DATA_W-3){1'b0}}, r_commit_pending, r_frame_err, 1'b0};
    end
  end

  // Shadow registers take write payloads; unused addresses never match.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w_exec_wr && (w_cmd_addr == ADDR_W'(k))) begin
          r_shadow[k] <= w_cmd_data;
        end
      end
    end
  end

  // Active registers reload from the pre-write shadows on a committed PWM boundary.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        r_active[k] <= '0;
      end
      r_cfg_update <= 1'b0;
    end else begin
      r_cfg_update <= w_apply;
      if (w_apply) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          r_active[k] <= r_shadow[k];
        end
      end
    end
  end

  // Commit request; a new commit in the same cycle as an apply stays pending.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_commit_pending <= 1'b0;
    end else if (w_commit_wr) begin
      r_commit_pending <= 1'b1;
    end else if (w_apply) begin
      r_commit_pending <= 1'b0;
    end
  end

  // Sticky short-frame flag, cleared by reading the control address.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_frame_err <= 1'b0;
    end else if (w_abort) begin
      r_frame_err <= 1'b1;
    end else if (w_exec_rd && (w_cmd_addr == c_ADDR_CTRL)) begin
      r_frame_err <= 1'b0;
    end
  end

  // Read reply buffer, then published at frame end so it is stable all next frame.
  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      r_rd_buf    <= 16'h0000;
      r_data_send <= 16'h0000;
    end else begin
      if (w_exec_rd) begin
        r_rd_buf <= {1'b0, w_cmd_addr, w_rd_value};
      end
      if (w_reply_load) begin
        r_data_send <= r_rd_buf;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign cfg_out[g*DATA_W +: DATA_W] = r_active[g];
    end
  endgenerate

  assign data_send      = r_data_send;
  assign cfg_update     = r_cfg_update;
  assign commit_pending = r_commit_pending;
  assign frame_err      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_cfg_sequencer
// Description : Self-checking bench for spi_cfg_sequencer with a queue-based
//               scoreboard fed from a register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_sequencer;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 3;
  localparam int NUM_CFG = 6;
  localparam int SETTLE  = 2;

  logic                      clk = 1'b0;
  logic                      rst_internal = 1'b0;
  logic                      sck = 1'b0;
  logic                      cs = 1'b1;
  logic [15:0]               copi_word = 16'h0000;
  logic [DATA_W-1:0]         status_in = '0;
  logic                      pwm_sync = 1'b0;
  logic [15:0]               data_send;
  logic [NUM_CFG*DATA_W-1:0] cfg_out;
  logic                      cfg_update;
  logic                      commit_pending;
  logic                      frame_err;

  spi_cfg_sequencer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CFG(NUM_CFG),
    .SETTLE (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_internal  (rst_internal),
    .sck           (sck),
    .cs            (cs),
    .copi_word     (copi_word),
    .status_in     (status_in),
    .pwm_sync      (pwm_sync),
    .data_send     (data_send),
    .cfg_out       (cfg_out),
    .cfg_update    (cfg_update),
    .commit_pending(commit_pending),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model state (register-level view of the block)
  logic [DATA_W-1:0] m_shadow [NUM_CFG];
  logic [DATA_W-1:0] m_active [NUM_CFG];
  bit                m_pending;
  bit                m_ferr;
  logic [15:0]       m_rdbuf;
  logic [15:0]       m_send;

  // Scoreboard queues
  logic [15:0]               q_reply [$];
  logic [NUM_CFG*DATA_W-1:0] q_cfg [$];
  logic [15:0]               cur_exp;
  bit                        have_cur = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [NUM_CFG*DATA_W-1:0] act,
                       input logic [NUM_CFG*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CFG*DATA_W-1:0] model_cfg();
    logic [NUM_CFG*DATA_W-1:0] v;
    for (int k = 0; k < NUM_CFG; k++) v[k*DATA_W +: DATA_W] = m_active[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CFG; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_pending = 1'b0;
    m_ferr    = 1'b0;
    m_rdbuf   = 16'h0000;
    m_send    = 16'h0000;
  endtask

  // Effect of one frame on the register map, from the command rules.
  task automatic model_frame(input logic [15:0] w, input bit complete);
    int          a;
    logic [11:0] d;
    logic [11:0] v;
    if (!complete) begin
      m_ferr = 1'b1;
      return;
    end
    a = int'(w[14:12]);
    d = w[11:0];
    if (w[15]) begin
      if (a < NUM_CFG) m_shadow[a] = d;
      else if (a == 7 && d[0]) m_pending = 1'b1;
    end else begin
      if (a < NUM_CFG) v = m_active[a];
      else if (a == 6) v = status_in;
      else v = {9'b0, m_pending, m_ferr, 1'b0};
      if (a == 7) m_ferr = 1'b0;
      m_rdbuf = {1'b0, w[14:12], v};
    end
    m_send = m_rdbuf;
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_commit_pending"}, commit_pending, m_pending);
    check({tag, "_frame_err"}, frame_err, m_ferr);
    check({tag, "_cfg_out"}, cfg_out, model_cfg());
  endtask

  // Drive one SPI frame; the peripheral word shifts in on each SCK rise and
  // is cleared when CS deasserts.
  task automatic send_frame(input logic [15:0] word, input int rises);
    q_reply.push_back(m_send);
    cs = 1'b0;
    copi_word = 16'h0000;
    clk_wait(4);
    for (int i = 0; i < rises; i++) begin
      sck = 1'b1;
      copi_word = {copi_word[14:0], word[15-i]};
      clk_wait(4);
      sck = 1'b0;
      clk_wait(4);
    end
    cs = 1'b1;
    copi_word = 16'h0000;
    clk_wait(10);
    model_frame(word, rises == 16);
    check_state("frame");
  endtask

  task automatic pulse_pwm();
    pwm_sync = 1'b1;
    if (m_pending) begin
      for (int k = 0; k < NUM_CFG; k++) m_active[k] = m_shadow[k];
      m_pending = 1'b0;
      q_cfg.push_back(model_cfg());
    end
    clk_wait(1);
    pwm_sync = 1'b0;
    clk_wait(2);
  endtask

  // Monitor: every cfg_update cycle must match a predicted apply.
  always @(negedge clk) begin
    if (rst_internal === 1'b1 && cfg_update === 1'b1) begin
      if (q_cfg.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cfg_update: got cfg_update=1 expected 0 at %0t", $time);
      end else begin
        check("cfg_update_apply", cfg_out, q_cfg.pop_front());
      end
    end
  end

  // Monitor: reply word at the start and end of every frame.
  always @(negedge cs) begin
    if (q_reply.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL reply_queue_empty: got frame start expected none at %0t", $time);
    end else begin
      cur_exp  = q_reply.pop_front();
      have_cur = 1'b1;
      check("reply_frame_start", data_send, cur_exp);
    end
  end

  always @(posedge cs) begin
    if (have_cur && rst_internal === 1'b1) check("reply_frame_end", data_send, cur_exp);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          r;
    model_reset();
    clk_wait(3);
    rst_internal = 1'b1;
    clk_wait(3);
    check("reset_cfg_out", cfg_out, '0);
    check("reset_data_send", data_send, 16'h0000);
    check("reset_cfg_update", cfg_update, 1'b0);
    check("reset_commit_pending", commit_pending, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);

    // Write, commit, apply
    send_frame(16'h9ABC, 16);
    send_frame(16'hF001, 16);
    pulse_pwm();
    check("apply_reg1", cfg_out[23:12], 12'hABC);
    check_state("apply");

    // Shadow write without commit: PWM boundaries must not apply it
    send_frame(16'h9123, 16);
    repeat (8) pulse_pwm();
    check_state("no_commit");

    // Pipelined read of the active register
    send_frame(16'h1000, 16);
    send_frame(16'h0000, 16);

    // Short frame, then control read clears the flag
    send_frame(16'h9777, 9);
    send_frame(16'h7000, 16);
    send_frame(16'h0000, 16);

    // Status read and ignored write to the status address
    status_in = 12'h5A5;
    send_frame(16'h6000, 16);
    send_frame(16'hE0FF, 16);
    send_frame(16'h0000, 16);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      status_in = 12'($urandom);
      w = 16'($urandom);
      if ($urandom_range(0, 4) == 0) w = 16'hF000 | 16'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 16;
      send_frame(w, r);
      if ($urandom_range(0, 2) == 0) pulse_pwm();
    end

    // Make sure something is committed before the reset test
    send_frame(16'h9DEF, 16);
    send_frame(16'hF001, 16);
    pulse_pwm();
    send_frame(16'h1000, 16);

    // Reset while the sequencer is holding for the settle delay
    q_reply.push_back(m_send);
    cs = 1'b0;
    copi_word = 16'h0000;
    w = 16'h9321;
    clk_wait(4);
    for (int i = 0; i < 16; i++) begin
      sck = 1'b1;
      copi_word = {copi_word[14:0], w[15-i]};
      if (i == 15) begin
        clk_wait(4);
        rst_internal = 1'b0;
      end else begin
        clk_wait(4);
      end
      sck = 1'b0;
      clk_wait(4);
    end
    cs = 1'b1;
    copi_word = 16'h0000;
    clk_wait(4);
    model_reset();
    rst_internal = 1'b1;
    clk_wait(4);
    check("midrst_cfg_out", cfg_out, '0);
    check("midrst_data_send", data_send, 16'h0000);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_commit_pending", commit_pending, 1'b0);

    // Normal operation afterwards
    send_frame(16'hA555, 16);
    send_frame(16'hF001, 16);
    pulse_pwm();
    send_frame(16'h2000, 16);
    send_frame(16'h0000, 16);
    clk_wait(5);

    check("cfg_queue_drained", q_cfg.size(), 0);
    check("reply_queue_drained", q_reply.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
